// File: rtl/round_sequencer.sv
// round_sequencer: best-of-N match controller (countdown, timed play, scoring, winner).
// Define ROUND_SEQ_PAUSE_EN to add the pause_toggle input and the PAUSED state.
module round_sequencer #(
    parameter int SEC_DIV    = 65_000_000,
    parameter int TICK_DIV   = 1_300_000,
    parameter int COUNTDOWN  = 3,
    parameter int WIN_ROUNDS = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_req,
    input  logic                              restart_req,
    input  logic                              p1_collision,
    input  logic                              p2_collision,
`ifdef ROUND_SEQ_PAUSE_EN
    input  logic                              pause_toggle,
`endif
    output logic [2:0]                        state,
    output logic [$clog2(COUNTDOWN+1)-1:0]    countdown,
    output logic                              move_tick,
    output logic                              round_reset,
    output logic [$clog2(WIN_ROUNDS+1)-1:0]   score1,
    output logic [$clog2(WIN_ROUNDS+1)-1:0]   score2,
    output logic [1:0]                        round_winner,
    output logic [1:0]                        match_winner
);
    localparam int CW   = $clog2(COUNTDOWN+1);
    localparam int SW   = $clog2(WIN_ROUNDS+1);
    localparam int SECW = $clog2(SEC_DIV+1);
    localparam int TW   = $clog2(TICK_DIV);
    localparam logic [2:0] IDLE = 3'd0, CNTDN = 3'd1, PLAY = 3'd2, RND_END = 3'd3, MATCH = 3'd4;
`ifdef ROUND_SEQ_PAUSE_EN
    localparam logic [2:0] PAUSED = 3'd5;
`endif

    logic [2:0]      cur, nxt;
    logic [SECW-1:0] sec_cnt;
    logic [TW-1:0]   tick_cnt;
    logic            sec_end, tick_last, hit, score_done;

    assign sec_end    = sec_cnt == SECW'(SEC_DIV-1);
    assign tick_last  = tick_cnt == TW'(TICK_DIV-1);
    assign hit        = cur == PLAY && nxt == RND_END;
    assign score_done = score1 == SW'(WIN_ROUNDS) || score2 == SW'(WIN_ROUNDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (restart_req) nxt = IDLE;
        else
            case (cur)
                IDLE:    nxt = start_req ? CNTDN : IDLE;
                CNTDN:   nxt = sec_end && countdown == CW'(1) ? PLAY : CNTDN;
`ifdef ROUND_SEQ_PAUSE_EN
                PLAY:    nxt = p1_collision || p2_collision ? RND_END : pause_toggle ? PAUSED : PLAY;
                PAUSED:  nxt = pause_toggle ? PLAY : PAUSED;
`else
                PLAY:    nxt = p1_collision || p2_collision ? RND_END : PLAY;
`endif
                RND_END: nxt = !sec_end ? RND_END : score_done ? MATCH : CNTDN;
                MATCH:   nxt = MATCH;
                default: nxt = IDLE;
            endcase
    end

    // Shared second counter runs only in COUNTDOWN and ROUND_END, restarting on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_cnt      <= '0;
            tick_cnt     <= '0;
            countdown    <= '0;
            round_reset  <= 1'b0;
            score1       <= '0;
            score2       <= '0;
            round_winner <= 2'b00;
            match_winner <= 2'b00;
        end else begin
            sec_cnt      <= cur != nxt || sec_end || (cur != CNTDN && cur != RND_END) ? '0 : sec_cnt + SECW'(1);
`ifdef ROUND_SEQ_PAUSE_EN
            tick_cnt     <= cur == PLAY && (nxt == PLAY || nxt == PAUSED) ? (tick_last ? '0 : tick_cnt + TW'(1)) :
                            cur == PAUSED && nxt != IDLE ? tick_cnt : '0;
`else
            tick_cnt     <= cur == PLAY && nxt == PLAY ? (tick_last ? '0 : tick_cnt + TW'(1)) : '0;
`endif
            countdown    <= nxt != CNTDN ? '0 : cur != CNTDN ? CW'(COUNTDOWN) : sec_end ? countdown - CW'(1) : countdown;
            round_reset  <= nxt == CNTDN && cur != CNTDN;
            score1       <= nxt == IDLE ? '0 : hit && p2_collision && !p1_collision && score1 != SW'(WIN_ROUNDS) ? score1 + SW'(1) : score1;
            score2       <= nxt == IDLE ? '0 : hit && p1_collision && !p2_collision && score2 != SW'(WIN_ROUNDS) ? score2 + SW'(1) : score2;
            round_winner <= nxt == IDLE || (cur == RND_END && nxt == CNTDN) ? 2'b00 : hit ? {p1_collision, p2_collision} : round_winner;
            match_winner <= nxt == IDLE ? 2'b00 : cur == RND_END && nxt == MATCH ? (score1 == SW'(WIN_ROUNDS) ? 2'b01 : 2'b10) : match_winner;
        end
    end

    always_comb begin
        state     = cur;
        move_tick = cur == PLAY && tick_last;
    end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed test of round_sequencer with small timing parameters.
module tb_round_sequencer;
    logic       clk = 1'b0, rst = 1'b0;
    logic       start_req = 1'b0, restart_req = 1'b0, p1_collision = 1'b0, p2_collision = 1'b0;
`ifdef ROUND_SEQ_PAUSE_EN
    logic       pause_toggle = 1'b0;
`endif
    logic [2:0] state;
    logic [1:0] countdown, score1, score2, round_winner, match_winner;
    logic       move_tick, round_reset;
    int         n_cmp = 0, n_err = 0;

    round_sequencer #(.SEC_DIV(4), .TICK_DIV(3), .COUNTDOWN(3), .WIN_ROUNDS(2)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .restart_req(restart_req),
        .p1_collision(p1_collision), .p2_collision(p2_collision),
`ifdef ROUND_SEQ_PAUSE_EN
        .pause_toggle(pause_toggle),
`endif
        .state(state), .countdown(countdown), .move_tick(move_tick), .round_reset(round_reset),
        .score1(score1), .score2(score2), .round_winner(round_winner), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget);
        int k = 0;
        while (int'(state) != s && k < budget) begin
            step();
            k++;
        end
        chk("wait_state", int'(state), s);
    endtask

    initial begin
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_countdown", countdown, 0);
        chk("rst_round_reset", round_reset, 0);
        chk("rst_move_tick", move_tick, 0);
        chk("rst_scores", {score1, score2}, 0);
        chk("rst_winners", {round_winner, match_winner}, 0);
        rst = 1'b1;
        step();
        chk("idle_hold", state, 0);

        // Countdown: 3x4, 2x4, 1x4 then PLAY
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("cd_round_reset", round_reset, 1);
        for (int i = 0; i < 12; i++) begin
            chk("cd_state", state, 1);
            chk("cd_digit", countdown, 3 - i / 4);
            if (i == 1) chk("cd_round_reset_pulse", round_reset, 0);
            step();
        end
        chk("play_entry", state, 2);
        chk("play_countdown", countdown, 0);

        // PLAY ticks on cycles 3, 6, 9
        for (int c = 1; c <= 10; c++) begin
            chk("play_tick", move_tick, (c % 3 == 0) ? 1 : 0);
            step();
        end

        // p1 collision: P2 scores; collisions in ROUND_END and COUNTDOWN are ignored
        p1_collision = 1'b1;
        step();
        p1_collision = 1'b0;
        chk("r1_score2", score2, 1);
        chk("r1_winner", round_winner, 2);
        chk("r1_move_tick", move_tick, 0);
        p2_collision = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("r1_hold", state, 3);
            step();
        end
        chk("r1_next_state", state, 1);
        chk("r1_round_reset", round_reset, 1);
        chk("r1_winner_clr", round_winner, 0);
        chk("r1_countdown", countdown, 3);
        for (int i = 0; i < 11; i++) step();
        p2_collision = 1'b0;
        chk("ignored_scores", {score1, score2}, 1);
        wait_state(2, 4);

        // Simultaneous collision: draw, no score change
        p1_collision = 1'b1;
        p2_collision = 1'b1;
        step();
        p1_collision = 1'b0;
        p2_collision = 1'b0;
        chk("draw_state", state, 3);
        chk("draw_winner", round_winner, 3);
        chk("draw_scores", {score1, score2}, 1);
        wait_state(1, 6);
        wait_state(2, 14);

        // Two p2 collisions: P1 takes the match
        p2_collision = 1'b1;
        step();
        p2_collision = 1'b0;
        chk("r3_score1", score1, 1);
        chk("r3_winner", round_winner, 1);
        wait_state(1, 6);
        wait_state(2, 14);
        p2_collision = 1'b1;
        step();
        p2_collision = 1'b0;
        chk("r4_score1", score1, 2);
        for (int i = 0; i < 4; i++) begin
            chk("r4_hold", state, 3);
            step();
        end
        chk("match_state", state, 4);
        chk("match_winner", match_winner, 1);
        chk("match_scores", {score1, score2}, 9);
        chk("match_round_reset", round_reset, 0);
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("match_start_ignored", state, 4);
        restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        chk("restart_state", state, 0);
        chk("restart_scores", {score1, score2}, 0);
        chk("restart_winners", {round_winner, match_winner}, 0);

        // Asynchronous reset mid-COUNTDOWN
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        step();
        step();
        chk("pre_rst_state", state, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_countdown", countdown, 0);
        chk("async_rst_round_reset", round_reset, 0);
        rst = 1'b1;
        step();
        chk("post_rst_state", state, 0);
        chk("post_rst_round_reset", round_reset, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
